aibcr3_dcc_cal_ctrl: RTL and testbench

Calibration controller driving the DCC delay-line/phase-detector macro from the opposite side of its interface. It issues `launch`/`measure` strobes and consumes the `t_up`/`t_down` phase-detector verdicts. It runs an 11-step successive-approximation search over the delay code and presents that code as split gray fields `f_gray`/`i_gray`. On completion it asserts `dll_lock` and publishes the half-period reference `pvt_ref_half_gry` for continuous-calibration mode.

---
 rtl/aibcr3_dcc_cal_pkg.sv | 35 +++
 rtl/aibcr3_dcc_cal_sync.sv | 20 ++
 rtl/aibcr3_dcc_cal_ctrl.sv | 162 ++++++++++++++++
 tb/tb_aibcr3_dcc_cal_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3_dcc_cal_pkg.sv
// Shared types and helpers for the DCC calibration controller.
// Delay code is 11 bits: an 8-bit fine field over a 3-bit coarse field, each gray-coded on its own.
package aibcr3_dcc_cal_pkg;

  localparam int CODE_W   = 11;
  localparam int FINE_W   = 8;
  localparam int COARSE_W = 3;

  localparam logic [CODE_W-1:0] CODE_MID = 11'h400;
  localparam logic [CODE_W-1:0] CODE_MAX = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_MEASURE,
    ST_SYNC,
    ST_DECIDE,
    ST_LOCKED
  } cal_state_t;

  // Binary code to {gray(fine), gray(coarse)}; the two fields never share a carry.
  function automatic logic [CODE_W-1:0] gray_fields(input logic [CODE_W-1:0] c);
    logic [FINE_W-1:0]   f;
    logic [COARSE_W-1:0] i;
    f = c[CODE_W-1:COARSE_W];
    i = c[COARSE_W-1:0];
    return {f ^ (f >> 1), i ^ (i >> 1)};
  endfunction

  function automatic logic code_sat(input logic [CODE_W-1:0] c);
    return (c == '0) || (c == CODE_MAX);
  endfunction

endpackage

// File: rtl/aibcr3_dcc_cal_sync.sv
// Two-bit flop-chain synchronizer for the phase-detector verdicts.
module aibcr3_dcc_cal_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [2*STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[2*STAGES-3:0], d};
  end

  assign q = chain[2*STAGES-1 -: 2];

endmodule

// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC calibration controller: 11-step SAR search over the delay code, then lock.
// AIBCR3_DCC_TRACK_EN: after lock, keep measuring and nudge the code by +/-1 per step.
//
//   state      | meaning
//   IDLE       | outputs cleared, waiting for cal_en
//   LAUNCH     | one-cycle launch strobe
//   WAIT       | SETTLE_CYC cycles for the delay line to settle
//   MEASURE    | one-cycle measure strobe
//   SYNC       | SYNC_STAGES cycles for verdicts to cross the synchronizer
//   DECIDE     | resolve bit b (or track step) from synchronized verdicts
//   LOCKED     | search done, dll_lock high
module aibcr3_dcc_cal_ctrl
  import aibcr3_dcc_cal_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_dcd,
  input  logic              dll_reset_n,
  input  logic              cal_en,
  input  logic              t_up,
  input  logic              t_down,
  output logic              launch,
  output logic              measure,
  output logic [FINE_W-1:0] f_gray,
  output logic [COARSE_W-1:0] i_gray,
  output logic [CODE_W-1:0] pvt_ref_half_gry,
  output logic              dll_lock,
  output logic              cal_busy,
  output logic              cal_sat
);

  cal_state_t        state;
  logic [7:0]        cnt;
  logic [3:0]        bit_idx;
  logic [CODE_W-1:0] code;
  logic [1:0]        verdict;
  logic              up_s;
  logic              dn_s;
  logic              keep;
  logic [CODE_W-1:0] sar_code;

  aibcr3_dcc_cal_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk_dcd),
    .reset_n (dll_reset_n),
    .d       ({t_up, t_down}),
    .q       (verdict)
  );

  assign up_s = verdict[1];
  assign dn_s = verdict[0];
  // Both-high or both-low is treated as "delay too long".
  assign keep = up_s & ~dn_s;

  always_comb begin
    sar_code = code;
    sar_code[bit_idx] = keep;
    if (bit_idx != 4'd0) sar_code[bit_idx - 4'd1] = 1'b1;
  end

`ifdef AIBCR3_DCC_TRACK_EN
  logic [CODE_W-1:0] trk_code;

  always_comb begin
    trk_code = code;
    if (keep && code != CODE_MAX)               trk_code = code + 1'b1;
    else if (dn_s && !up_s && code != '0)       trk_code = code - 1'b1;
  end
`endif

  always_ff @(posedge clk_dcd) begin
    if (!dll_reset_n || (!cal_en && state != ST_IDLE)) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      code             <= '0;
      launch           <= 1'b0;
      measure          <= 1'b0;
      f_gray           <= '0;
      i_gray           <= '0;
      pvt_ref_half_gry <= '0;
      dll_lock         <= 1'b0;
      cal_busy         <= 1'b0;
      cal_sat          <= 1'b0;
    end else begin
      launch  <= 1'b0;
      measure <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cal_en) begin
            code             <= CODE_MID;
            bit_idx          <= 4'd10;
            {f_gray, i_gray} <= gray_fields(CODE_MID);
            launch           <= 1'b1;
            cal_busy         <= 1'b1;
            state            <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= 8'(SETTLE_CYC - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 8'd0) begin
            measure <= 1'b1;
            state   <= ST_MEASURE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_MEASURE: begin
          cnt   <= 8'(SYNC_STAGES - 1);
          state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (cnt == 8'd0) state <= ST_DECIDE;
          else             cnt   <= cnt - 8'd1;
        end
        ST_DECIDE: begin
`ifdef AIBCR3_DCC_TRACK_EN
          // dll_lock doubles as the "already searched, now tracking" flag.
          if (dll_lock) begin
            code             <= trk_code;
            {f_gray, i_gray} <= gray_fields(trk_code);
            pvt_ref_half_gry <= gray_fields(trk_code >> 1);
            cal_sat          <= code_sat(trk_code);
            launch           <= 1'b1;
            state            <= ST_LAUNCH;
          end else
`endif
          if (bit_idx == 4'd0) begin
            code             <= sar_code;
            {f_gray, i_gray} <= gray_fields(sar_code);
            pvt_ref_half_gry <= gray_fields(sar_code >> 1);
            cal_sat          <= code_sat(sar_code);
            dll_lock         <= 1'b1;
            cal_busy         <= 1'b0;
            state            <= ST_LOCKED;
          end else begin
            code             <= sar_code;
            {f_gray, i_gray} <= gray_fields(sar_code);
            bit_idx          <= bit_idx - 4'd1;
            launch           <= 1'b1;
            state            <= ST_LAUNCH;
          end
        end
        ST_LOCKED: begin
`ifdef AIBCR3_DCC_TRACK_EN
          launch <= 1'b1;
          state  <= ST_LAUNCH;
`else
          state  <= ST_LOCKED;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// Directed bench for aibcr3_dcc_cal_ctrl; tracking checks follow AIBCR3_DCC_TRACK_EN.
module tb_aibcr3_dcc_cal_ctrl;

  logic        clk_dcd;
  logic        dll_reset_n;
  logic        cal_en;
  logic        t_up;
  logic        t_down;
  logic        launch;
  logic        measure;
  logic [7:0]  f_gray;
  logic [2:0]  i_gray;
  logic [10:0] pvt_ref_half_gry;
  logic        dll_lock;
  logic        cal_busy;
  logic        cal_sat;

  int n_run;
  int n_fail;
  int cyc;
  int pd_mode;
  int thr;
  logic [10:0] dut_code;
  logic        any_launch;

  aibcr3_dcc_cal_ctrl #(
    .SETTLE_CYC  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_dcd          (clk_dcd),
    .dll_reset_n      (dll_reset_n),
    .cal_en           (cal_en),
    .t_up             (t_up),
    .t_down           (t_down),
    .launch           (launch),
    .measure          (measure),
    .f_gray           (f_gray),
    .i_gray           (i_gray),
    .pvt_ref_half_gry (pvt_ref_half_gry),
    .dll_lock         (dll_lock),
    .cal_busy         (cal_busy),
    .cal_sat          (cal_sat)
  );

  initial clk_dcd = 1'b0;
  always #5 clk_dcd = ~clk_dcd;

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  function automatic logic [2:0] g2b3(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    for (int k = 1; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  // Phase-detector model: 0 threshold, 1 both high, 2 up only, 3 down only.
  always_comb begin
    dut_code = {g2b8(f_gray), g2b3(i_gray)};
    t_up   = 1'b0;
    t_down = 1'b0;
    case (pd_mode)
      0: begin
        t_up   = (int'(dut_code) < thr);
        t_down = !(int'(dut_code) < thr);
      end
      1: begin t_up = 1'b1; t_down = 1'b1; end
      2: t_up = 1'b1;
      3: t_down = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk_dcd);
      #1;
      cyc++;
    end
  endtask

  // Ends in cycle 0: cal_en high, DUT still in IDLE.
  task automatic start_cal();
    @(posedge clk_dcd);
    #1;
    cal_en = 1'b1;
    cyc    = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".launch"}, 32'(launch), 32'd0);
    chk({tag, ".measure"}, 32'(measure), 32'd0);
    chk({tag, ".f_gray"}, 32'(f_gray), 32'd0);
    chk({tag, ".i_gray"}, 32'(i_gray), 32'd0);
    chk({tag, ".pvt_ref"}, 32'(pvt_ref_half_gry), 32'd0);
    chk({tag, ".dll_lock"}, 32'(dll_lock), 32'd0);
    chk({tag, ".cal_busy"}, 32'(cal_busy), 32'd0);
    chk({tag, ".cal_sat"}, 32'(cal_sat), 32'd0);
  endtask

  task automatic stop_cal();
    cal_en = 1'b0;
    adv(2);
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    cyc         = 0;
    pd_mode     = 0;
    thr         = 1234;
    cal_en      = 1'b0;
    dll_reset_n = 1'b0;
    adv(3);
    chk_all_zero("reset");
    dll_reset_n = 1'b1;
    adv(2);

    // Strict threshold at 1234: code 1234 reads "too long", so the search settles on 1233.
    start_cal();
    chk("c0.launch", 32'(launch), 32'd0);
    for (int c = 1; c <= 144; c++) begin
      adv(1);
      chk("step.launch", 32'(launch), 32'((c <= 143) && ((c - 1) % 13 == 0)));
      chk("step.measure", 32'(measure), 32'((c <= 143) && ((c - 1) % 13 == 9)));
      if (c == 1) begin
        chk("c1.f_gray", 32'(f_gray), 32'h0C0);
        chk("c1.i_gray", 32'(i_gray), 32'd0);
        chk("c1.cal_busy", 32'(cal_busy), 32'd1);
      end
      if (c == 143) chk("c143.dll_lock", 32'(dll_lock), 32'd0);
    end
    chk("t1233.dll_lock", 32'(dll_lock), 32'd1);
    chk("t1233.f_gray", 32'(f_gray), 32'h0D7);
    chk("t1233.i_gray", 32'(i_gray), 32'd1);
    chk("t1233.pvt_ref", 32'(pvt_ref_half_gry), 32'({8'h6B, 3'd0}));
    chk("t1233.cal_sat", 32'(cal_sat), 32'd0);
    chk("t1233.cal_busy", 32'(cal_busy), 32'd0);
    cal_en = 1'b0;
    adv(1);
    chk_all_zero("cal_en_drop_locked");
    adv(1);

    // Detector flips between 1234 and 1235: locks at 1234.
    thr = 1235;
    start_cal();
    adv(144);
    chk("t1234.dll_lock", 32'(dll_lock), 32'd1);
    chk("t1234.f_gray", 32'(f_gray), 32'h0D7);
    chk("t1234.i_gray", 32'(i_gray), 32'd3);
    chk("t1234.pvt_ref", 32'(pvt_ref_half_gry), 32'({8'h6B, 3'd1}));
    chk("t1234.cal_sat", 32'(cal_sat), 32'd0);
    pd_mode = 3;
    adv(13);
    chk("trk157.i_gray", 32'(i_gray), 32'd3);
    adv(1);
`ifdef AIBCR3_DCC_TRACK_EN
    chk("trk158.i_gray", 32'(i_gray), 32'd1);
    chk("trk158.pvt_ref", 32'(pvt_ref_half_gry), 32'({8'h6B, 3'd0}));
`else
    chk("frz158.i_gray", 32'(i_gray), 32'd3);
    chk("frz158.pvt_ref", 32'(pvt_ref_half_gry), 32'({8'h6B, 3'd1}));
`endif
    adv(13);
`ifdef AIBCR3_DCC_TRACK_EN
    chk("trk171.i_gray", 32'(i_gray), 32'd0);
    chk("trk171.launch", 32'(launch), 32'd1);
`else
    chk("frz171.i_gray", 32'(i_gray), 32'd3);
    chk("frz171.launch", 32'(launch), 32'd0);
`endif
    chk("trk171.f_gray", 32'(f_gray), 32'h0D7);
    chk("trk171.dll_lock", 32'(dll_lock), 32'd1);
    chk("trk171.cal_busy", 32'(cal_busy), 32'd0);
    stop_cal();
    pd_mode = 0;

    // Reset pulled in the middle of WAIT.
    start_cal();
    adv(5);
    chk("c5.cal_busy", 32'(cal_busy), 32'd1);
    dll_reset_n = 1'b0;
    adv(1);
    chk_all_zero("rst_mid_wait");
    any_launch = 1'b0;
    for (int c = 0; c < 20; c++) begin
      adv(1);
      any_launch = any_launch | launch;
    end
    chk("rst_hold.no_launch", 32'(any_launch), 32'd0);
    cal_en = 1'b0;
    dll_reset_n = 1'b1;
    adv(2);

    // Both verdicts high: every bit cleared.
    pd_mode = 1;
    start_cal();
    adv(144);
    chk("both.dll_lock", 32'(dll_lock), 32'd1);
    chk("both.f_gray", 32'(f_gray), 32'd0);
    chk("both.i_gray", 32'(i_gray), 32'd0);
    chk("both.pvt_ref", 32'(pvt_ref_half_gry), 32'd0);
    chk("both.cal_sat", 32'(cal_sat), 32'd1);
    stop_cal();

    // Up only: every bit kept, 2047.
    pd_mode = 2;
    start_cal();
    adv(144);
    chk("up.dll_lock", 32'(dll_lock), 32'd1);
    chk("up.f_gray", 32'(f_gray), 32'h080);
    chk("up.i_gray", 32'(i_gray), 32'd4);
    chk("up.pvt_ref", 32'(pvt_ref_half_gry), 32'({8'h40, 3'd4}));
    chk("up.cal_sat", 32'(cal_sat), 32'd1);
    stop_cal();

    // cal_en dropped during the DECIDE of bit 4 (cycle 13*7).
    pd_mode = 0;
    thr = 1234;
    start_cal();
    adv(91);
    chk("c91.cal_busy", 32'(cal_busy), 32'd1);
    cal_en = 1'b0;
    adv(1);
    chk_all_zero("drop_bit4");
    adv(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
